// File: rtl/tamagotchi_pkg.sv
// rtl/tamagotchi_pkg.sv - shared estado codes, vital width and life-state type
package tamagotchi_pkg;

   localparam int VITAL_W = 4;

   // estado codes driven by controlador_estados
   localparam logic [3:0] IDLE       = 4'b0001;
   localparam logic [3:0] COMENDO    = 4'b0010;
   localparam logic [3:0] DORMINDO   = 4'b0100;
   localparam logic [3:0] DANDO_AULA = 4'b1000;
   localparam logic [3:0] MORTO      = 4'b0000;

   typedef enum logic {
      ST_VIVO  = 1'b0,
      ST_MORTO = 1'b1
   } vida_e;

endpackage

// File: rtl/divisor_segundo.sv
// rtl/divisor_segundo.sv - one-cycle tick once every CLK_HZ clock cycles
module divisor_segundo #(
   parameter int CLK_HZ = 100
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_seg
);

   localparam int               CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tick_q;

   assign cnt_d    = (cnt_q == CNT_ULT) ? '0 : cnt_q + 1'b1;
   assign tick_seg = tick_q;

   // Free-running cycle counter; the tick register fires on the cycle after the wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_q == CNT_ULT);
      end
   end

endmodule

// File: rtl/controlador_vitais.sv
// rtl/controlador_vitais.sv - pet vital counters, alert and sticky death flag; FELICIDADE_EN adds felicidade
module controlador_vitais
   import tamagotchi_pkg::*;
#(
   parameter int CLK_HZ        = 100,
   parameter int VALOR_MAX     = 15,
   parameter int VALOR_INICIAL = 10,
   parameter int LIMIAR_ALERTA = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         estado,
   output logic [VITAL_W-1:0] fome,
   output logic [VITAL_W-1:0] energia,
   output logic               morreu,
   output logic               alerta,
   output logic               tick_seg
`ifdef FELICIDADE_EN
   ,
   output logic [VITAL_W-1:0] felicidade
`endif
);

   localparam logic [VITAL_W-1:0] V_MAX = VITAL_W'(VALOR_MAX);
   localparam logic [VITAL_W-1:0] V_INI = VITAL_W'(VALOR_INICIAL);
   localparam logic [VITAL_W-1:0] V_LIM = VITAL_W'(LIMIAR_ALERTA);

   // Add with a one-bit-wider intermediate so overflow clamps to V_MAX
   function automatic logic [VITAL_W-1:0] sat_inc(input logic [VITAL_W-1:0] v, input logic [1:0] n);
      logic [VITAL_W:0] s;
      s = {1'b0, v} + {{(VITAL_W-1){1'b0}}, n};
      return (s > {1'b0, V_MAX}) ? V_MAX : s[VITAL_W-1:0];
   endfunction

   // Subtract with a borrow bit so underflow clamps to zero
   function automatic logic [VITAL_W-1:0] sat_dec(input logic [VITAL_W-1:0] v, input logic [1:0] n);
      logic [VITAL_W:0] s;
      s = {1'b0, v} - {{(VITAL_W-1){1'b0}}, n};
      return s[VITAL_W] ? '0 : s[VITAL_W-1:0];
   endfunction

   vida_e              vida_q;
   logic               par_q;
   logic [VITAL_W-1:0] fome_q, fome_d;
   logic [VITAL_W-1:0] energia_q, energia_d;
   logic               morte_d;
   logic               baixo;
`ifdef FELICIDADE_EN
   logic [VITAL_W-1:0] felic_q, felic_d;
`endif

   divisor_segundo #(.CLK_HZ(CLK_HZ)) u_divisor (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_seg (tick_seg)
   );

   // Candidate vitals for the current tick; par_q gates the every-other-second events
   always_comb begin
      fome_d    = fome_q;
      energia_d = energia_q;
`ifdef FELICIDADE_EN
      felic_d   = felic_q;
`endif
      case (estado)
         MORTO: begin
         end
         COMENDO: begin
            fome_d = sat_inc(fome_q, 2'd2);
            if (par_q) energia_d = sat_dec(energia_q, 2'd1);
`ifdef FELICIDADE_EN
            if (par_q) felic_d = sat_inc(felic_q, 2'd1);
`endif
         end
         DORMINDO: begin
            energia_d = sat_inc(energia_q, 2'd2);
            if (par_q) fome_d = sat_dec(fome_q, 2'd1);
`ifdef FELICIDADE_EN
            if (par_q) felic_d = sat_dec(felic_q, 2'd1);
`endif
         end
         DANDO_AULA: begin
            fome_d    = sat_dec(fome_q, 2'd1);
            energia_d = sat_dec(energia_q, 2'd1);
`ifdef FELICIDADE_EN
            felic_d   = sat_inc(felic_q, 2'd1);
`endif
         end
         default: begin
            fome_d = sat_dec(fome_q, 2'd1);
            if (par_q) energia_d = sat_dec(energia_q, 2'd1);
`ifdef FELICIDADE_EN
            if (par_q) felic_d = sat_dec(felic_q, 2'd1);
`endif
         end
      endcase
   end

   assign morte_d = (fome_d == '0) || (energia_d == '0);

   // Vitals and the half-rate phase bit advance only on ticks, and freeze once dead
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q     <= 1'b0;
         fome_q    <= V_INI;
         energia_q <= V_INI;
`ifdef FELICIDADE_EN
         felic_q   <= V_INI;
`endif
      end else if (tick_seg) begin
         par_q <= ~par_q;
         if (vida_q == ST_VIVO) begin
            fome_q    <= fome_d;
            energia_q <= energia_d;
`ifdef FELICIDADE_EN
            felic_q   <= felic_d;
`endif
         end
      end
   end

   // Life FSM: dies on the same tick a vital reaches zero; only reset revives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vida_q <= ST_VIVO;
      end else begin
         case (vida_q)
            ST_VIVO:  if (tick_seg && morte_d) vida_q <= ST_MORTO;
            ST_MORTO: vida_q <= ST_MORTO;
            default:  vida_q <= ST_VIVO;
         endcase
      end
   end

`ifdef FELICIDADE_EN
   assign baixo      = (fome_q <= V_LIM) || (energia_q <= V_LIM) || (felic_q <= V_LIM);
   assign felicidade = felic_q;
`else
   assign baixo      = (fome_q <= V_LIM) || (energia_q <= V_LIM);
`endif

   assign fome    = fome_q;
   assign energia = energia_q;
   assign morreu  = (vida_q == ST_MORTO);
   assign alerta  = ~morreu & baixo;

endmodule
